// File: rtl/mem_stage_nb.sv
// ---------------------------------------------------------------------------
// mem_stage_nb - memory-access pipeline stage between EX and WB with a
// non-blocking SRAM-like read response interface.
//
// A load sits in WAIT until its own response arrives on data_sram_data_ok.
// The returned word is buffered in rbuf so that it is held while WB is not
// accepting. Responses that belong to flushed or cancelled requests are
// counted in cancel_cnt and discarded when they arrive.
//
// Optional feature macro: MS_LOAD_BYPASS_EN
//   defined   : a fresh response in WAIT is forwarded combinationally. The
//               load reaches WB and the forward path in the data_ok cycle.
//   undefined : the load result always comes from rbuf, one cycle later.
//
// Bus layouts, MSB first:
//   es_to_ms_bus : {load_op[6:0], res_from_mem, mem_req, gr_we, dest[4:0],
//                   alu_result[DATA_W-1:0], pc[31:0]}   (47+DATA_W bits)
//   ms_to_ws_bus : {gr_we, dest[4:0], final_result[DATA_W-1:0], pc[31:0]}
//   ms_fwd_bus   : {fwd_valid, fwd_blocked, dest[4:0], final_result}
//   load_op bits [0..6] = lb, lh, lw, lbu, lhu, lwu, ld.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   ws_allowin           WB can accept this cycle
//   ms_allowin           MS can accept from EX
//   es_to_ms_valid/bus   instruction from EX
//   es_cancel_req        an issued request was flushed before reaching MS
//   ms_to_ws_valid/bus   instruction to WB
//   ms_fwd_bus           forwarding/interlock information for ID
//   data_sram_data_ok    read response valid
//   data_sram_rdata      read response data
//   ms_flush             pipeline flush (exception or ertn)
// ---------------------------------------------------------------------------
module mem_stage_nb #(
  parameter  int DATA_W     = 32,
  parameter  int MAX_CANCEL = 3,
  localparam int CNT_W      = $clog2(MAX_CANCEL + 1),
  localparam int ES_BUS_W   = 47 + DATA_W,
  localparam int WS_BUS_W   = 38 + DATA_W,
  localparam int FWD_BUS_W  = 7 + DATA_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ws_allowin,
  output logic                 ms_allowin,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_W-1:0]  es_to_ms_bus,
  input  logic                 es_cancel_req,
  output logic                 ms_to_ws_valid,
  output logic [WS_BUS_W-1:0]  ms_to_ws_bus,
  output logic [FWD_BUS_W-1:0] ms_fwd_bus,
  input  logic                 data_sram_data_ok,
  input  logic [DATA_W-1:0]    data_sram_rdata,
  input  logic                 ms_flush
);

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_READY = 2'd2
  } ms_state_e;

  ms_state_e         state_q, state_d;
  logic [6:0]        load_op_q, load_op_d;
  logic              res_from_mem_q, res_from_mem_d;
  logic              gr_we_q, gr_we_d;
  logic [4:0]        dest_q, dest_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [CNT_W-1:0]  cancel_cnt_q, cancel_cnt_d;

  // Incoming EX bus fields
  logic [6:0]        es_load_op_s;
  logic              es_res_from_mem_s;
  logic              es_mem_req_s;
  logic              es_gr_we_s;
  logic [4:0]        es_dest_s;
  logic [DATA_W-1:0] es_alu_s;
  logic [31:0]       es_pc_s;

  assign {es_load_op_s, es_res_from_mem_s, es_mem_req_s, es_gr_we_s,
          es_dest_s, es_alu_s, es_pc_s} = es_to_ms_bus;

  logic              ms_valid_s;
  logic              cnt_zero_s;
  logic              fresh_ok_s;
  logic              stale_ok_s;
  logic              wait_fresh_s;
  logic              ms_ready_go_s;
  logic              accept_s;
  logic              flush_inc_s;
  logic [DATA_W-1:0] load_src_s;
  logic [DATA_W-1:0] load_data_s;
  logic [DATA_W-1:0] final_result_s;
  logic              fwd_valid_s;

  // Byte/half/word selection by address, then sign or zero extension.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [6:0]        op,
    input logic [2:0]        addr,
    input logic [DATA_W-1:0] word
  );
    logic [DATA_W-1:0] sh;
    logic [5:0]        amt;
    if (DATA_W == 64) begin
      amt = {addr, 3'b000};
    end else begin
      amt = {1'b0, addr[1:0], 3'b000};
    end
    sh = word >> amt;
    case (op)
      7'b0000001: load_extract = DATA_W'($signed(sh[7:0]));
      7'b0000010: load_extract = DATA_W'($signed(sh[15:0]));
      7'b0000100: load_extract = DATA_W'($signed(sh[31:0]));
      7'b0001000: load_extract = DATA_W'(sh[7:0]);
      7'b0010000: load_extract = DATA_W'(sh[15:0]);
      7'b0100000: load_extract = DATA_W'(sh[31:0]);
      7'b1000000: load_extract = word;
      default:    load_extract = word;
    endcase
  endfunction

  assign ms_valid_s   = (state_q != MS_EMPTY);
  assign cnt_zero_s   = (cancel_cnt_q == {CNT_W{1'b0}});
  // A response is ours only if no discarded responses are still pending.
  assign fresh_ok_s   = data_sram_data_ok && cnt_zero_s;
  assign stale_ok_s   = data_sram_data_ok && !cnt_zero_s;
  assign wait_fresh_s = (state_q == MS_WAIT) && fresh_ok_s;

`ifdef MS_LOAD_BYPASS_EN
  assign ms_ready_go_s = (state_q == MS_READY) || wait_fresh_s;
  assign load_src_s    = wait_fresh_s ? data_sram_rdata : rbuf_q;
`else
  assign ms_ready_go_s = (state_q == MS_READY);
  assign load_src_s    = rbuf_q;
`endif

  assign ms_allowin  = !ms_valid_s || (ms_ready_go_s && ws_allowin);
  assign accept_s    = es_to_ms_valid && ms_allowin && !ms_flush;
  // A flushed load whose response is still outstanding leaves one stale
  // response behind; a fresh response arriving in the same cycle is simply
  // consumed and dropped.
  assign flush_inc_s = ms_flush && (state_q == MS_WAIT) && !fresh_ok_s;

  assign load_data_s    = load_extract(load_op_q, alu_q[2:0], load_src_s);
  assign final_result_s = res_from_mem_q ? load_data_s : alu_q;
  assign fwd_valid_s    = ms_valid_s && gr_we_q;

  assign ms_to_ws_valid = ms_valid_s && ms_ready_go_s && !ms_flush;
  assign ms_to_ws_bus   = {gr_we_q, dest_q, final_result_s, pc_q};
  assign ms_fwd_bus     = {fwd_valid_s, fwd_valid_s && !ms_ready_go_s,
                           dest_q, final_result_s};

  // Next-state logic for the stage FSM, latched fields, rbuf and cancel count
  always_comb begin
    state_d        = state_q;
    load_op_d      = load_op_q;
    res_from_mem_d = res_from_mem_q;
    gr_we_d        = gr_we_q;
    dest_d         = dest_q;
    alu_d          = alu_q;
    pc_d           = pc_q;
    rbuf_d         = rbuf_q;

    if (ms_flush) begin
      state_d = MS_EMPTY;
    end else if (accept_s) begin
      state_d        = es_mem_req_s ? MS_WAIT : MS_READY;
      load_op_d      = es_load_op_s;
      res_from_mem_d = es_res_from_mem_s;
      gr_we_d        = es_gr_we_s;
      dest_d         = es_dest_s;
      alu_d          = es_alu_s;
      pc_d           = es_pc_s;
    end else if (ms_valid_s && ms_ready_go_s && ws_allowin) begin
      state_d = MS_EMPTY;
    end else if (wait_fresh_s) begin
      state_d = MS_READY;
    end else begin
      state_d = state_q;
    end

    if (wait_fresh_s) begin
      rbuf_d = data_sram_rdata;
    end else begin
      rbuf_d = rbuf_q;
    end

    cancel_cnt_d = cancel_cnt_q + CNT_W'(es_cancel_req) + CNT_W'(flush_inc_s)
                 - CNT_W'(stale_ok_s);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= MS_EMPTY;
      load_op_q      <= 7'd0;
      res_from_mem_q <= 1'b0;
      gr_we_q        <= 1'b0;
      dest_q         <= 5'd0;
      alu_q          <= {DATA_W{1'b0}};
      pc_q           <= 32'd0;
      rbuf_q         <= {DATA_W{1'b0}};
      cancel_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      load_op_q      <= load_op_d;
      res_from_mem_q <= res_from_mem_d;
      gr_we_q        <= gr_we_d;
      dest_q         <= dest_d;
      alu_q          <= alu_d;
      pc_q           <= pc_d;
      rbuf_q         <= rbuf_d;
      cancel_cnt_q   <= cancel_cnt_d;
    end
  end

endmodule
